// File: rtl/retstack_pkg.sv
// Shared encodings for the return-stack controller: FSM states, rp adder
// commands and default stack window bounds.
package retstack_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SPILL    = 2'd1,
        ST_FILL_DEC = 2'd2,
        ST_FILL     = 2'd3
    } state_e;

    localparam logic [1:0] RP_HOLD = 2'b00;
    localparam logic [1:0] RP_INC  = 2'b01;
    localparam logic [1:0] RP_DEC  = 2'b10;

    localparam logic [15:0] RS_BASE_DEFAULT  = 16'h4000;
    localparam logic [15:0] RS_LIMIT_DEFAULT = 16'h4FFF;

endpackage

// File: rtl/reg_16b.sv
// Generic 16-bit load-enable register with asynchronous active-low clear.
module reg_16b (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] d,
    output logic [15:0] q
);

    logic [15:0] data_q;
    logic [15:0] data_d;

    always_comb begin
        data_d = data_q;
        if (en) data_d = d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_q <= '0;
        else        data_q <= data_d;
    end

    assign q = data_q;

endmodule

// File: rtl/subsystem_retstack.sv
// Return-stack controller: TOS held in a register, older entries spill to and
// refill from data memory at address rp, which an external rp adder maintains.
module subsystem_retstack
    import retstack_pkg::*;
#(
    parameter logic [15:0] BASE  = RS_BASE_DEFAULT,
    parameter logic [15:0] LIMIT = RS_LIMIT_DEFAULT
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic [15:0] push_data,
    input  logic [15:0] rp,
    output logic [1:0]  rp_inc,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic [15:0] tos,
    output logic        tos_valid,
    output logic        busy,
    output logic        overflow,
    output logic        underflow
);

    state_e      state_q, state_d;
    logic        tos_valid_q, tos_valid_d;
    logic [15:0] pend_q, pend_d;
    logic        overflow_q, overflow_d;
    logic        underflow_q, underflow_d;
    logic        tos_en;
    logic [15:0] tos_d;

    reg_16b u_tos (
        .clk   (CLK),
        .rst_n (reset),
        .en    (tos_en),
        .d     (tos_d),
        .q     (tos)
    );

    always_comb begin
        state_d     = state_q;
        tos_valid_d = tos_valid_q;
        pend_d      = pend_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        tos_en      = 1'b0;
        tos_d       = push_data;

        unique case (state_q)
            ST_IDLE: begin
                if (push && pop) begin
                    // Replace-in-place when an entry exists; otherwise the push wins
                    // but the pop still reports an empty stack.
                    tos_en      = 1'b1;
                    tos_valid_d = 1'b1;
                    if (!tos_valid_q) underflow_d = 1'b1;
                end else if (push) begin
                    if (!tos_valid_q) begin
                        tos_en      = 1'b1;
                        tos_valid_d = 1'b1;
                    end else if (rp >= LIMIT) begin
                        overflow_d = 1'b1;
                    end else begin
                        pend_d  = push_data;
                        state_d = ST_SPILL;
                    end
                end else if (pop) begin
                    if (!tos_valid_q)    underflow_d = 1'b1;
                    else if (rp == BASE) tos_valid_d = 1'b0;
                    else                 state_d     = ST_FILL_DEC;
                end
            end
            ST_SPILL: begin
                if (mem_ack) begin
                    tos_en  = 1'b1;
                    tos_d   = pend_q;
                    state_d = ST_IDLE;
                end
            end
            ST_FILL_DEC: state_d = ST_FILL;
            ST_FILL: begin
                if (mem_ack) begin
                    tos_en  = 1'b1;
                    tos_d   = mem_rdata;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            tos_valid_q <= 1'b0;
            pend_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tos_valid_q <= tos_valid_d;
            pend_q      <= pend_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Memory strobes decode straight from the state flop so an async reset
    // withdraws an in-flight request immediately.
    always_comb begin
        mem_req = (state_q == ST_SPILL) || (state_q == ST_FILL);
        mem_we  = (state_q == ST_SPILL);
        rp_inc  = RP_HOLD;
        if (state_q == ST_SPILL && mem_ack) rp_inc = RP_INC;
        if (state_q == ST_FILL_DEC)         rp_inc = RP_DEC;
    end

    assign mem_addr  = mem_req ? rp : 16'h0000;
    assign mem_wdata = tos;
    assign tos_valid = tos_valid_q;
    assign busy      = (state_q != ST_IDLE);
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_subsystem_retstack.sv
// Directed bench for subsystem_retstack with a behavioural rp adder alongside.
module tb_subsystem_retstack;

    localparam logic [15:0] BASE  = 16'h4000;
    localparam logic [15:0] LIMIT = 16'h4002;

    logic        CLK = 1'b0;
    logic        reset;
    logic        push, pop;
    logic [15:0] push_data;
    logic [15:0] rp;
    logic [1:0]  rp_inc;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic [15:0] tos;
    logic        tos_valid, busy, overflow, underflow;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    // rp adder stand-in: reset to BASE, step by rp_inc.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset)               rp <= BASE;
        else if (rp_inc == 2'b01) rp <= rp + 16'd1;
        else if (rp_inc == 2'b10) rp <= rp - 16'd1;
    end

    subsystem_retstack #(.BASE(BASE), .LIMIT(LIMIT)) dut (
        .CLK       (CLK),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .rp        (rp),
        .rp_inc    (rp_inc),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .tos       (tos),
        .tos_valid (tos_valid),
        .busy      (busy),
        .overflow  (overflow),
        .underflow (underflow)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        push, pop;
        logic [15:0] din;
        logic        ack;
        logic [15:0] rdata;
        logic [15:0] e_tos;
        logic        e_tv, e_busy, e_req, e_we;
        logic [15:0] e_addr, e_wdata, e_rp;
        logic [1:0]  e_inc;
        logic        e_ovf, e_udf;
    } vec_t;

    vec_t vecs[$];

    initial begin
        reset = 1'b0; push = 0; pop = 0; push_data = 0; mem_rdata = 0; mem_ack = 0;

        // Expected values describe outputs in the cycle the inputs are applied.
        //            push pop din      ack rdata     tos      tv bsy req we addr     wdata    rp       inc  ovf udf
        vecs.push_back('{0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h4000, 2'd0, 0, 0});
        vecs.push_back('{1, 0, 16'h1234, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h4000, 2'd0, 0, 0});
        vecs.push_back('{0, 0, 16'h0000, 0, 16'h0000, 16'h1234, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h4000, 2'd0, 0, 0});
        vecs.push_back('{1, 0, 16'hABCD, 0, 16'h0000, 16'h1234, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h4000, 2'd0, 0, 0});
        vecs.push_back('{0, 0, 16'h0000, 0, 16'h0000, 16'h1234, 1, 1, 1, 1, 16'h4000, 16'h1234, 16'h4000, 2'd0, 0, 0});
        vecs.push_back('{1, 0, 16'hFFFF, 0, 16'h0000, 16'h1234, 1, 1, 1, 1, 16'h4000, 16'h1234, 16'h4000, 2'd0, 0, 0});
        vecs.push_back('{0, 0, 16'h0000, 1, 16'h0000, 16'h1234, 1, 1, 1, 1, 16'h4000, 16'h1234, 16'h4000, 2'd1, 0, 0});
        vecs.push_back('{0, 0, 16'h0000, 0, 16'h0000, 16'hABCD, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h4001, 2'd0, 0, 0});
        vecs.push_back('{0, 1, 16'h0000, 0, 16'h0000, 16'hABCD, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h4001, 2'd0, 0, 0});
        vecs.push_back('{0, 0, 16'h0000, 0, 16'h0000, 16'hABCD, 1, 1, 0, 0, 16'h0000, 16'h0000, 16'h4001, 2'd2, 0, 0});
        vecs.push_back('{0, 1, 16'h0000, 0, 16'hDEAD, 16'hABCD, 1, 1, 1, 0, 16'h4000, 16'h0000, 16'h4000, 2'd0, 0, 0});
        vecs.push_back('{0, 0, 16'h0000, 1, 16'h1234, 16'hABCD, 1, 1, 1, 0, 16'h4000, 16'h0000, 16'h4000, 2'd0, 0, 0});
        vecs.push_back('{0, 0, 16'h0000, 0, 16'h0000, 16'h1234, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h4000, 2'd0, 0, 0});
        vecs.push_back('{0, 1, 16'h0000, 0, 16'h0000, 16'h1234, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h4000, 2'd0, 0, 0});
        vecs.push_back('{0, 0, 16'h0000, 0, 16'h0000, 16'h1234, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h4000, 2'd0, 0, 0});
        vecs.push_back('{0, 1, 16'h0000, 0, 16'h0000, 16'h1234, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h4000, 2'd0, 0, 0});
        vecs.push_back('{0, 0, 16'h0000, 0, 16'h0000, 16'h1234, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h4000, 2'd0, 0, 1});
        vecs.push_back('{1, 1, 16'h5555, 0, 16'h0000, 16'h1234, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h4000, 2'd0, 0, 1});
        vecs.push_back('{0, 0, 16'h0000, 0, 16'h0000, 16'h5555, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h4000, 2'd0, 0, 1});
        vecs.push_back('{1, 1, 16'h6666, 0, 16'h0000, 16'h5555, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h4000, 2'd0, 0, 1});
        vecs.push_back('{0, 0, 16'h0000, 0, 16'h0000, 16'h6666, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h4000, 2'd0, 0, 1});
        vecs.push_back('{1, 0, 16'h7777, 0, 16'h0000, 16'h6666, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h4000, 2'd0, 0, 1});
        vecs.push_back('{0, 0, 16'h0000, 1, 16'h0000, 16'h6666, 1, 1, 1, 1, 16'h4000, 16'h6666, 16'h4000, 2'd1, 0, 1});
        vecs.push_back('{1, 0, 16'h8888, 0, 16'h0000, 16'h7777, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h4001, 2'd0, 0, 1});
        vecs.push_back('{0, 0, 16'h0000, 1, 16'h0000, 16'h7777, 1, 1, 1, 1, 16'h4001, 16'h7777, 16'h4001, 2'd1, 0, 1});
        vecs.push_back('{1, 0, 16'h9999, 0, 16'h0000, 16'h8888, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h4002, 2'd0, 0, 1});
        vecs.push_back('{0, 0, 16'h0000, 0, 16'h0000, 16'h8888, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h4002, 2'd0, 1, 1});

        repeat (2) @(negedge CLK);
        reset = 1'b1;

        foreach (vecs[i]) begin
            push      = vecs[i].push;
            pop       = vecs[i].pop;
            push_data = vecs[i].din;
            mem_ack   = vecs[i].ack;
            mem_rdata = vecs[i].rdata;
            #1;
            check($sformatf("v%0d tos", i),       tos,               vecs[i].e_tos);
            check($sformatf("v%0d tos_valid", i), {15'd0, tos_valid}, {15'd0, vecs[i].e_tv});
            check($sformatf("v%0d busy", i),      {15'd0, busy},      {15'd0, vecs[i].e_busy});
            check($sformatf("v%0d mem_req", i),   {15'd0, mem_req},   {15'd0, vecs[i].e_req});
            check($sformatf("v%0d mem_we", i),    {15'd0, mem_we},    {15'd0, vecs[i].e_we});
            check($sformatf("v%0d mem_addr", i),  mem_addr,          vecs[i].e_addr);
            if (vecs[i].e_we)
                check($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].e_wdata);
            check($sformatf("v%0d rp", i),        rp,                vecs[i].e_rp);
            check($sformatf("v%0d rp_inc", i),    {14'd0, rp_inc},    {14'd0, vecs[i].e_inc});
            check($sformatf("v%0d overflow", i),  {15'd0, overflow},  {15'd0, vecs[i].e_ovf});
            check($sformatf("v%0d underflow", i), {15'd0, underflow}, {15'd0, vecs[i].e_udf});
            @(negedge CLK);
        end

        // Reset clears the sticky flags and the stack.
        push = 0; pop = 0; mem_ack = 0;
        reset = 1'b0;
        #1;
        check("rst overflow",  {15'd0, overflow},  16'd0);
        check("rst underflow", {15'd0, underflow}, 16'd0);
        check("rst tos",       tos,                16'h0000);
        check("rst rp",        rp,                 BASE);
        @(negedge CLK);
        reset = 1'b1;

        // Reset in the middle of a spill abandons the access.
        push = 1; push_data = 16'h1111;
        @(negedge CLK);
        push_data = 16'h2222;
        @(negedge CLK);
        push = 0;
        #1;
        check("spill req",  {15'd0, mem_req}, 16'd1);
        check("spill addr", mem_addr,         16'h4000);
        check("spill data", mem_wdata,        16'h1111);
        @(negedge CLK);
        #2;
        reset = 1'b0;
        #1;
        check("abort mem_req",   {15'd0, mem_req},   16'd0);
        check("abort busy",      {15'd0, busy},      16'd0);
        check("abort tos_valid", {15'd0, tos_valid}, 16'd0);
        check("abort rp",        rp,                 BASE);
        check("abort rp_inc",    {14'd0, rp_inc},    16'd0);
        @(negedge CLK);
        reset = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 16'hBEEF;
        @(negedge CLK);
        mem_ack = 1'b0;
        #1;
        check("late ack mem_req",   {15'd0, mem_req},   16'd0);
        check("late ack rp",        rp,                 BASE);
        check("late ack tos",       tos,                16'h0000);
        check("late ack tos_valid", {15'd0, tos_valid}, 16'd0);
        check("late ack busy",      {15'd0, busy},      16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/subsystem_retstack.md
Name: subsystem_retstack

Overview:
- Return-stack controller that consumes `rp` from subsystem_rpadder and drives that block's `rp_inc`.
- Keeps the top-of-stack (TOS) in a register. Older entries spill to data memory at address `rp` and refill from it, through a req/ack memory port.
- Serves the control unit's call (push) and return (pop) operations.

Parameters:
- BASE, 16'h4000: empty-stack value of `rp`; equals the rp adder's reset value (16384).
- LIMIT, 16'h4FFF: first address that may not be spilled to; a spill is permitted while `rp` < LIMIT.

Ports:
- CLK  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; the same net also drives subsystem_rpadder.
- push  in  1  push request; accepted only when busy=0.
- pop  in  1  pop request; accepted only when busy=0.
- push_data  in  16  value to push; sampled on acceptance.
- rp  in  16  current return pointer from subsystem_rpadder.
- rp_inc  out  2  to subsystem_rpadder: 00 hold, 01 +1, 10 -1; 11 never driven.
- mem_req  out  1  memory access request; held until mem_ack.
- mem_we  out  1  1 = write (spill), 0 = read (fill); valid while mem_req=1.
- mem_addr  out  16  equals `rp` while mem_req=1, else 0.
- mem_wdata  out  16  spill data.
- mem_rdata  in  16  fill data; valid in the mem_ack cycle.
- mem_ack  in  1  single-cycle completion pulse; may arrive in the first req cycle.
- tos  out  16  current top of stack.
- tos_valid  out  1  TOS register holds an entry.
- busy  out  1  FSM not in IDLE.
- overflow  out  1  sticky; cleared only by reset.
- underflow  out  1  sticky; cleared only by reset.

Behaviour:
- Reset (asynchronous, on reset=0):
  - state=IDLE; tos=0, tos_valid=0, pend=0.
  - mem_req, mem_we, busy, overflow, underflow = 0; rp_inc=00.
  - Reset during SPILL or FILL abandons the access: mem_req drops immediately and the pending ack is ignored. `rp` returns to BASE through the shared reset.
- States: IDLE, SPILL, FILL_DEC, FILL.
- IDLE, push only, tos_valid=0: tos<=push_data, tos_valid<=1 at the next edge; no memory access.
- IDLE, push only, tos_valid=1:
  - If rp==LIMIT: set overflow, drop the push, stack unchanged.
  - Otherwise: pend<=push_data and go to SPILL.
- SPILL:
  - Drive mem_req=1, mem_we=1, mem_addr=rp, mem_wdata=tos.
  - In the mem_ack cycle: rp_inc=01 for that cycle only, tos<=pend, return to IDLE.
- IDLE, pop only, tos_valid=0: set underflow; no other change.
- IDLE, pop only, tos_valid=1, rp==BASE: tos_valid<=0, tos unchanged, stay in IDLE.
- IDLE, pop only, tos_valid=1, rp>BASE: go to FILL_DEC.
- FILL_DEC: rp_inc=10 for exactly one cycle, then go to FILL.
- FILL:
  - Drive mem_req=1, mem_we=0, mem_addr=rp (already decremented).
  - In the mem_ack cycle: tos<=mem_rdata, return to IDLE.
- Popped value: the caller reads `tos` in the same cycle it asserts pop.
- push and pop together in IDLE:
  - tos_valid=1: tos<=push_data; no memory access, no rp change.
  - tos_valid=0: handled as push only, and underflow is set.
- rp_inc is 00 in every cycle not listed above.
- push/pop while busy=1 are ignored; the requester must hold them.
- Latency:
  - Push or pop without memory: 1 cycle.
  - Push with spill: 1 + ack wait cycles (minimum 2).
  - Pop with fill: 2 + ack wait cycles (minimum 3).
- `rp` is not checked for wrap past 16'hFFFF, because LIMIT bounds it.

Decomposition:
- Package retstack_pkg holds:
  - state encoding (IDLE=2'd0, SPILL=2'd1, FILL_DEC=2'd2, FILL=2'd3);
  - RP_HOLD=2'b00, RP_INC=2'b01, RP_DEC=2'b10;
  - defaults for BASE and LIMIT.
- The TOS register reuses the existing reg_16b.
- No new sub-module; the rp adder is instantiated beside this block at the next level up.

Test Plan:
1. After reset: push 16'h1234 -> next edge tos=16'h1234, tos_valid=1, mem_req=0, rp stays 16'h4000.
2. Push 16'hABCD with ack after 2 cycles:
   - mem_req=1, mem_we=1, mem_addr=16'h4000, mem_wdata=16'h1234 until ack;
   - rp_inc=01 only in the ack cycle;
   - then rp=16'h4001, tos=16'hABCD.
3. Pop from the state in 2, mem_rdata=16'h1234:
   - FILL_DEC drives rp_inc=10 for one cycle, so rp=16'h4000;
   - read at 16'h4000; tos=16'h1234; busy low again after the ack.
4. Pop with rp=BASE, tos_valid=1 -> tos_valid=0, no mem_req. A second pop sets underflow=1.
5. LIMIT=16'h4002: fill the stack until rp=16'h4002 with tos_valid=1, then push -> overflow=1, no mem_req, tos unchanged.
6. Assert reset mid-SPILL before ack -> mem_req=0 at once, tos_valid=0, rp=16'h4000. A late mem_ack has no effect.
